// File: rtl/cdc_fin_sout_sched.sv
// Round-robin scheduler sharing one fast-to-slow level synchroniser channel.
// Each granted word is held for HOLD_CYCLES, then the channel idles at 0 for GAP_CYCLES.
module cdc_fin_sout_sched #(
  parameter int N_REQ       = 4,
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                     fast_clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ack,
  output logic [DW-1:0]            xfer_data,
  output logic                     xfer_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int GW    = $clog2(N_REQ);
  localparam int CMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [GW-1:0]   rr_ptr_reg;
  logic [DW-1:0]   req_word [N_REQ];
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [GW:0]     cand;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign req_word[gi] = req_data[gi*DW +: DW];
  end

  // First requesting index at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ))
        cand = cand - (GW+1)'(N_REQ);
      if (!pick_found && req[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rr_ptr_reg <= '0;
      req_ack    <= '0;
      xfer_data  <= '0;
      xfer_valid <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_idx;
            xfer_data  <= req_word[pick_idx];
            xfer_valid <= 1'b1;
            busy       <= 1'b1;
            cnt_reg    <= CW'(HOLD_CYCLES - 1);
            state_reg  <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            xfer_data         <= '0;
            xfer_valid        <= 1'b0;
            req_ack[grant_id] <= 1'b1;
            cnt_reg           <= CW'(GAP_CYCLES - 1);
            rr_ptr_reg        <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_reg         <= GAP;
          end
        end
        GAP: begin
          // req is deliberately ignored here so the acked requester can drop it.
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            busy      <= 1'b0;
            grant_id  <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_fin_sout_sched.sv
// Directed bench for cdc_fin_sout_sched: a per-cycle vector table for a single
// transfer plus hand-written round-robin, reset and persistence sequences.
module tb_cdc_fin_sout_sched;

  logic        fast_clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  xfer_data;
  logic        xfer_valid;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  words [4];

  int n_checks = 0;
  int n_fail   = 0;

  cdc_fin_sout_sched #(.N_REQ(4), .DW(8), .HOLD_CYCLES(8), .GAP_CYCLES(8)) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .xfer_data (xfer_data),
    .xfer_valid(xfer_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  always_comb req_data = {words[3], words[2], words[1], words[0]};

  typedef struct {
    logic [3:0] req;
    logic [7:0] d2;
    logic [3:0] ack;
    logic [7:0] xd;
    logic       xv;
    logic [1:0] gid;
    logic       bz;
    logic       cg;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic wait_valid(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      tick();
      if (xfer_valid) break;
    end
    if (i == lim) chk("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ack(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      tick();
      if (req_ack != 4'b0) break;
    end
    if (i == lim) chk("wait_ack_timeout", 32'd1, 32'd0);
  endtask

  // Never more than one ack bit at once.
  always @(negedge fast_clk) begin
    if (req_ack != 4'b0) chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
  end

  initial begin
    int prev_v, last_i, n_gr, ack_seen;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev_v, last_i, n_gr, ack_seen;

    for (int i = 0; i < 18; i++) begin
      tbl[i].req = (i <= 8) ? 4'b0100 : 4'b0000;
      tbl[i].d2  = (i >= 3) ? 8'hE2 : 8'h2E;
      tbl[i].ack = (i == 8) ? 4'b0100 : 4'b0000;
      tbl[i].xd  = (i <= 7) ? 8'h2E : 8'h00;
      tbl[i].xv  = (i <= 7);
      tbl[i].gid = 2'd2;
      tbl[i].bz  = (i <= 15);
      tbl[i].cg  = (i <= 15);
    end

    // Reset held for 3 cycles with every requester asking.
    reset = 1'b1;
    req   = 4'hF;
    for (int i = 0; i < 4; i++) words[i] = 8'h10 + 8'(i);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_xfer_data",  32'(xfer_data),  32'h0);
      chk("rst_xfer_valid", 32'(xfer_valid), 32'h0);
      chk("rst_req_ack",    32'(req_ack),    32'h0);
      chk("rst_busy",       32'(busy),       32'h0);
      chk("rst_grant_id",   32'(grant_id),   32'h0);
    end
    reset = 1'b0;

    // All four held high: grants 0,1,2,3,0 spaced 17 cycles apart.
    prev_v = 0; last_i = 0; n_gr = 0;
    for (int i = 1; i <= 69; i++) begin
      tick();
      if (xfer_valid && prev_v == 0) begin
        chk("rr4_grant_id", 32'(grant_id), 32'(n_gr % 4));
        chk("rr4_xfer_data", 32'(xfer_data), 32'h10 + 32'(n_gr % 4));
        if (n_gr == 0) chk("rr4_first_edge", 32'(i), 32'd1);
        else           chk("rr4_spacing", 32'(i - last_i), 32'd17);
        last_i = i;
        n_gr++;
      end
      prev_v = int'(xfer_valid);
    end
    chk("rr4_grant_count", 32'(n_gr), 32'd5);

    reset = 1'b1;
    req   = 4'h0;
    tick();
    reset = 1'b0;

    // Single request on bit 2; word changes mid-HOLD and must be ignored.
    for (int i = 0; i < 18; i++) begin
      req      = tbl[i].req;
      words[2] = tbl[i].d2;
      tick();
      $display("vec %0d: ack=%h xd=%h xv=%0d gid=%0d busy=%0d", i, req_ack, xfer_data, xfer_valid, grant_id, busy);
      chk("vec_req_ack",    32'(req_ack),    32'(tbl[i].ack));
      chk("vec_xfer_data",  32'(xfer_data),  32'(tbl[i].xd));
      chk("vec_xfer_valid", 32'(xfer_valid), 32'(tbl[i].xv));
      chk("vec_busy",       32'(busy),       32'(tbl[i].bz));
      if (tbl[i].cg) chk("vec_grant_id", 32'(grant_id), 32'(tbl[i].gid));
    end

    // Pointer now at 3. Serve 1 alone, then 0 and 3 raised in GAP -> 3 then 0.
    words[2] = 8'h12;
    words[3] = 8'h00;
    req = 4'b0010;
    wait_valid(40);
    chk("rrp_grant1", 32'(grant_id), 32'd1);
    chk("rrp_data1",  32'(xfer_data), 32'h11);
    wait_ack(20);
    chk("rrp_ack1", 32'(req_ack), 32'b0010);
    req = 4'b1001;
    wait_valid(40);
    chk("rrp_grant3", 32'(grant_id), 32'd3);
    chk("rrp_zero_word_data", 32'(xfer_data), 32'h00);
    chk("rrp_zero_word_valid", 32'(xfer_valid), 32'd1);
    wait_ack(20);
    chk("rrp_ack3", 32'(req_ack), 32'b1000);
    req = 4'b0001;
    wait_valid(40);
    chk("rrp_grant0", 32'(grant_id), 32'd0);
    chk("rrp_data0",  32'(xfer_data), 32'h10);
    wait_ack(20);
    chk("rrp_ack0", 32'(req_ack), 32'b0001);
    req = 4'b0000;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("rrp_idle", 32'(busy), 32'd0);

    // Reset during HOLD: abort without ack and pointer returns to 0.
    words[2] = 8'h2E;
    req = 4'b0100;
    wait_valid(5);
    chk("mid_grant2", 32'(grant_id), 32'd2);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk("mid_xfer_data",  32'(xfer_data),  32'h0);
    chk("mid_xfer_valid", 32'(xfer_valid), 32'h0);
    chk("mid_busy",       32'(busy),       32'h0);
    chk("mid_req_ack",    32'(req_ack),    32'h0);
    reset = 1'b0;
    req   = 4'b0000;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ack != 4'b0) ack_seen++;
    end
    chk("mid_no_ack", 32'(ack_seen), 32'd0);
    req = 4'b1001;
    wait_valid(5);
    chk("mid_rr_ptr_zero", 32'(grant_id), 32'd0);
    wait_ack(20);
    chk("mid_ack0", 32'(req_ack), 32'b0001);
    req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_fin_sout_sched.md
Name: cdc_fin_sout_sched

Overview:
- Fast-domain scheduler that shares one fast-to-slow CDC synchroniser channel (8-bit level input, slow side samples it) between N_REQ requesters.
- Grants one requester at a time, round-robin, and captures its data word.
- Drives the captured word onto the channel, stable for HOLD_CYCLES fast clocks, then returns the channel to 0 for GAP_CYCLES so the slow side sees distinct events.
- Sits directly in front of the synchroniser's fast-domain data input.

Parameters:
- N_REQ, 4, number of requesters (legal range 2..8).
- DW, 8, data width; must match the synchroniser's data width.
- HOLD_CYCLES, 8, fast cycles each word is held on the channel. Must be >= 2 and must cover at least 2 slow clock periods plus margin.
- GAP_CYCLES, 8, fast cycles of 0 between words (>= 1).

Ports:
- fast_clk, input, 1, the block's only clock.
- reset, input, 1, synchronous, active-high reset.
- req, input, N_REQ, per-requester request level. Held high until the matching ack is seen.
- req_data, input, N_REQ*DW, requester i's word in bits [i*DW +: DW]. Must be stable while req[i] is high.
- req_ack, output, N_REQ, one-cycle pulse on bit i when requester i's transfer is finished.
- xfer_data, output, DW, to the synchroniser's data input. Equals 0 when no word is being held.
- xfer_valid, output, 1, high while xfer_data carries a held word (the HOLD state).
- grant_id, output, $clog2(N_REQ), index of the granted requester. Valid only while busy.
- busy, output, 1, high whenever the state is not IDLE.

Behaviour:
- States are IDLE, HOLD and GAP. All outputs are registered.
- Down-counter cnt has width $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- Reset (synchronous, sampled on fast_clk):
  - At the next edge: state=IDLE, xfer_data=0, xfer_valid=0, req_ack=0, busy=0, grant_id=0, rr_ptr=0, cnt=0.
  - Reset in any state aborts the transfer in progress and no ack is issued for it.
- IDLE:
  - If any req bit is high, pick the first set bit searching from rr_ptr upward with wrap-around (N_REQ-1 wraps to 0).
  - At that edge: grant_id=idx, xfer_data=req_data[idx], xfer_valid=1, busy=1, cnt=HOLD_CYCLES-1, state->HOLD.
  - If no req bit is high, remain in IDLE with all outputs 0.
- HOLD:
  - xfer_data stays at the word captured at grant. Changes on req_data or req are ignored.
  - While cnt != 0, cnt decrements each cycle.
  - When cnt==0: xfer_data=0, xfer_valid=0, req_ack[grant_id]=1 for exactly one cycle, cnt=GAP_CYCLES-1, rr_ptr=(grant_id+1) mod N_REQ, state->GAP.
  - Net effect: the word is visible for exactly HOLD_CYCLES cycles.
- GAP:
  - req is ignored. This gives the acked requester time to drop its req.
  - When cnt==0: state->IDLE, busy=0.
  - Net effect: 0 is driven for exactly GAP_CYCLES cycles.
- Throughput: the minimum spacing between grant edges is HOLD_CYCLES+GAP_CYCLES+1 cycles, because IDLE lasts at least one cycle.
- Persistent requester: a requester that keeps req high after its ack is treated as a new request and is served again in round-robin order.
- Round-robin boundaries:
  - rr_ptr advances only on a completed HOLD.
  - With a single active requester, that requester is re-granted every transfer.
- Zero data word: a word of 0 is legal. xfer_valid still goes high for it, but the slow side sees no value change.
- req_ack is never asserted for more than one bit at a time, and never outside the first GAP cycle.

Test Plan:
- Reset: hold reset high for 3 cycles with req=4'hF -> all outputs 0, no req_ack pulse. After release, the first grant goes to idx 0.
- Single request: req[2]=1 with data 8'h2E, sampled in IDLE at edge t.
  - xfer_data=8'h2E, xfer_valid=1, grant_id=2 for cycles t+1..t+8.
  - req_ack[2]=1 at t+9 only.
  - xfer_data=0 for t+9..t+16; busy=0 from t+17.
- All four requesters held high, data 8'h10..8'h13 -> grants in order 0,1,2,3,0. Successive grant edges are 17 cycles apart; each xfer_data matches its requester's word.
- Round-robin pointer: serve req[1] alone, then raise req[0] and req[3] together during GAP -> next grant is 3 (search starts at 2), then 0.
- Reset mid-HOLD at cycle t+4 of the single-request case -> xfer_data=0 and busy=0 at the next edge, req_ack[2] never pulses, and rr_ptr=0.
- Data stability: during HOLD, change req_data[2] from 8'h2E to 8'hE2 -> xfer_data stays 8'h2E for all 8 HOLD cycles.
